x_pipe_stage_n: RTL and testbench

//  - Parametrised N-lane execute->memory pipeline stage register; successor to the fixed 2-lane (top/bot) X/M register.
//  - Each lane holds operand A, operand B, instruction, ovf and a valid bit.
//  - Adds global stall, global flush, and per-lane kill that inserts NOP bubbles.
//  - Sits between the multi-issue ALU outputs and the memory stage; lane 0 is the oldest instruction.

---
 rtl/x_pipe_pkg.sv | 33 +++
 rtl/x_pipe_stage_n_lane.sv | 78 +++++++
 rtl/x_pipe_stage_n.sv | 110 +++++++++++
 tb/tb_x_pipe_stage_n.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/x_pipe_pkg.sv
// x_pipe_pkg: shared types and constants for the N-lane execute->memory stage.
// The lane_t layout matches the default 32-bit operand/instruction widths.
// Parameterised users size-cast the BUBBLE fields to their own widths.
package x_pipe_pkg;

    localparam int unsigned XP_DW = 32;
    localparam int unsigned XP_IW = 32;

    // Instruction word that the memory stage treats as "do nothing".
    localparam logic [XP_IW-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic             valid;
        logic             ovf;
        logic [XP_DW-1:0] a;
        logic [XP_DW-1:0] b;
        logic [XP_IW-1:0] instr;
    } lane_t;

    // An empty slot: no valid work, no overflow, NOP instruction, zeroed operands.
    localparam lane_t BUBBLE = '{valid: 1'b0, ovf: 1'b0, a: '0, b: '0, instr: NOP_INSTR};

    // Population count of a lane mask. It is used to count the bubbles inserted in a cycle.
    function automatic int unsigned count_ones(input logic [63:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/x_pipe_stage_n_lane.sv
// pipe_lane_reg: one lane of the X/M register and its hold/load/bubble mux.
// The reset value equals a bubble, so reset and flush leave the lane in the same state.
module pipe_lane_reg
    import x_pipe_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          take,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic [IW-1:0] instr_in,
    input  logic          ovf_in,
    output logic          valid_out,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [IW-1:0] instr_out,
    output logic          ovf_out
);

    logic          valid_q, valid_d;
    logic          ovf_q,   ovf_d;
    logic [DW-1:0] a_q,     a_d;
    logic [DW-1:0] b_q,     b_d;
    logic [IW-1:0] instr_q, instr_d;

    // Select the next lane contents: hold, accept the incoming entry, or insert a bubble.
    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        instr_d = instr_q;
        if (!hold) begin
            if (take) begin
                valid_d = 1'b1;
                ovf_d   = ovf_in;
                a_d     = a_in;
                b_d     = b_in;
                instr_d = instr_in;
            end else begin
                // A bubble never carries an overflow, so a killed entry cannot trap downstream.
                valid_d = BUBBLE.valid;
                ovf_d   = BUBBLE.ovf;
                a_d     = DW'(BUBBLE.a);
                b_d     = DW'(BUBBLE.b);
                instr_d = IW'(BUBBLE.instr);
            end
        end
    end

    // Lane state registers. Reset takes priority over hold on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            instr_q <= IW'(NOP_INSTR);
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            instr_q <= instr_d;
        end
    end

    assign valid_out = valid_q;
    assign ovf_out   = ovf_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign instr_out = instr_q;

endmodule

// File: rtl/x_pipe_stage_n.sv
// x_pipe_stage_n: N-lane execute->memory pipeline register with stall, flush and per-lane kill.
// Lane 0 holds the oldest instruction. Lanes are never reordered or compacted.
// Optional macro XPIPE_PERF_CNT_EN adds the saturating stall_cnt and bubble_cnt counters.
module x_pipe_stage_n
    import x_pipe_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DW    = 32,
    parameter int unsigned IW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic [LANES-1:0]    lane_kill,
    input  logic [LANES-1:0]    valid_in,
    input  logic [LANES*DW-1:0] data_a_in,
    input  logic [LANES*DW-1:0] data_b_in,
    input  logic [LANES*IW-1:0] instr_in,
    input  logic [LANES-1:0]    ovf_in,
    output logic [LANES-1:0]    valid_out,
    output logic [LANES*DW-1:0] data_a_out,
    output logic [LANES*DW-1:0] data_b_out,
    output logic [LANES*IW-1:0] instr_out,
    output logic [LANES-1:0]    ovf_out
`ifdef XPIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
`endif
);

    // Reject configurations that cannot work at elaboration time.
    if (LANES < 1 || LANES > 64 || DW < 1 || IW < 1 || CNT_W < 1) begin : g_bad_param
        $error("x_pipe_stage_n: illegal parameter value");
    end

    // Flush wins over stall. Because of this, a stall only holds the lanes when no flush is present.
    logic             hold;
    logic [LANES-1:0] take;

    assign hold = stall & ~flush;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        // A lane accepts its entry only on a plain load edge with valid set and no kill.
        assign take[gi] = ~flush & valid_in[gi] & ~lane_kill[gi];

        pipe_lane_reg #(
            .DW (DW),
            .IW (IW)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .hold      (hold),
            .take      (take[gi]),
            .a_in      (data_a_in[gi*DW +: DW]),
            .b_in      (data_b_in[gi*DW +: DW]),
            .instr_in  (instr_in[gi*IW +: IW]),
            .ovf_in    (ovf_in[gi]),
            .valid_out (valid_out[gi]),
            .a_out     (data_a_out[gi*DW +: DW]),
            .b_out     (data_b_out[gi*DW +: DW]),
            .instr_out (instr_out[gi*IW +: IW]),
            .ovf_out   (ovf_out[gi])
        );
    end

`ifdef XPIPE_PERF_CNT_EN
    localparam int unsigned SW = ((CNT_W > 7) ? CNT_W : 7) + 1;

    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [63:0]      bubble_mask;
    logic [SW-1:0]    bubble_sum;

    // Compute the next counter values. Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        bubble_mask  = '0;
        bubble_mask[LANES-1:0] = ~take;
        bubble_sum   = SW'(bubble_cnt_q) + SW'(count_ones(bubble_mask));
        if (hold) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else if (bubble_sum > SW'({CNT_W{1'b1}})) begin
            bubble_cnt_d = {CNT_W{1'b1}};
        end else begin
            bubble_cnt_d = bubble_sum[CNT_W-1:0];
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_x_pipe_stage_n.sv
// tb_x_pipe_stage_n: a scoreboard bench for x_pipe_stage_n with LANES=2 and CNT_W=4.
// The driver pushes the expected post-edge state for each cycle. The monitor pops one entry per edge and compares it.
module tb_x_pipe_stage_n;

    localparam int unsigned LANES = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [LANES-1:0]    valid;
        logic [LANES-1:0]    ovf;
        logic [LANES*DW-1:0] a;
        logic [LANES*DW-1:0] b;
        logic [LANES*IW-1:0] ins;
        logic [CNT_W-1:0]    scnt;
        logic [CNT_W-1:0]    bcnt;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset, stall, flush;
    logic [LANES-1:0]    lane_kill, valid_in, ovf_in;
    logic [LANES*DW-1:0] data_a_in, data_b_in;
    logic [LANES*IW-1:0] instr_in;
    logic [LANES-1:0]    valid_out, ovf_out;
    logic [LANES*DW-1:0] data_a_out, data_b_out;
    logic [LANES*IW-1:0] instr_out;
`ifdef XPIPE_PERF_CNT_EN
    logic [CNT_W-1:0]    stall_cnt, bubble_cnt;
`endif

    exp_t q[$];
    exp_t m;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    x_pipe_stage_n #(.LANES(LANES), .DW(DW), .IW(IW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .lane_kill  (lane_kill),
        .valid_in   (valid_in),
        .data_a_in  (data_a_in),
        .data_b_in  (data_b_in),
        .instr_in   (instr_in),
        .ovf_in     (ovf_in),
        .valid_out  (valid_out),
        .data_a_out (data_a_out),
        .data_b_out (data_b_out),
        .instr_out  (instr_out),
        .ovf_out    (ovf_out)
`ifdef XPIPE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input int unsigned n);
        int unsigned s;
        s = int'(c) + n;
        return (s > 15) ? 4'hF : CNT_W'(s);
    endfunction

    // Apply one cycle of stimulus and push the state the model expects after the next edge.
    task automatic drive(input logic rst, input logic st, input logic fl,
                         input logic [1:0] kill, input logic [1:0] vin,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ins, input logic [1:0] ovf);
        int unsigned nb;
        reset = rst; stall = st; flush = fl; lane_kill = kill; valid_in = vin;
        data_a_in = a; data_b_in = b; instr_in = ins; ovf_in = ovf;
        if (rst) begin
            m.valid = '0; m.ovf = '0; m.a = '0; m.b = '0; m.ins = '0; m.scnt = '0; m.bcnt = '0;
        end else if (fl) begin
            m.valid = '0; m.ovf = '0; m.a = '0; m.b = '0; m.ins = '0;
            m.bcnt = sat_add(m.bcnt, 2);
        end else if (st) begin
            m.scnt = sat_add(m.scnt, 1);
        end else begin
            nb = 0;
            for (int i = 0; i < 2; i++) begin
                if (vin[i] && !kill[i]) begin
                    m.valid[i] = 1'b1;
                    m.ovf[i] = ovf[i];
                    m.a[i*32 +: 32] = a[i*32 +: 32];
                    m.b[i*32 +: 32] = b[i*32 +: 32];
                    m.ins[i*32 +: 32] = ins[i*32 +: 32];
                end else begin
                    m.valid[i] = 1'b0;
                    m.ovf[i] = 1'b0;
                    m.a[i*32 +: 32] = '0;
                    m.b[i*32 +: 32] = '0;
                    m.ins[i*32 +: 32] = '0;
                    nb++;
                end
            end
            m.bcnt = sat_add(m.bcnt, nb);
        end
        q.push_back(m);
        $display("drive rst=%0b st=%0b fl=%0b kill=%b vin=%b ovf=%b", rst, st, fl, kill, vin, ovf);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: 1 time unit after every edge, compare the DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("valid_out",  64'(valid_out),  64'(e.valid));
                chk("ovf_out",    64'(ovf_out),    64'(e.ovf));
                chk("data_a_out", data_a_out, e.a);
                chk("data_b_out", data_b_out, e.b);
                chk("instr_out",  instr_out,  e.ins);
`ifdef XPIPE_PERF_CNT_EN
                chk("stall_cnt",  64'(stall_cnt),  64'(e.scnt));
                chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bcnt));
`endif
                $display("check t=%0t valid=%b ovf=%b instr=%h", $time, valid_out, ovf_out, instr_out);
            end
        end
    end

    initial begin
        m = '{default: '0};
        // Reset with every input at all-ones.
        drive(1, 1, 1, 2'b11, 2'b11, '1, '1, '1, 2'b11);
        // Load both lanes. Lane 0 has A=5 B=7 with overflow.
        drive(0, 0, 0, 2'b00, 2'b11, {32'd9, 32'd5}, {32'd3, 32'd7},
              {32'h0000_0013, 32'h0041_0005}, 2'b01);
        // Stall for three cycles while the inputs change.
        drive(0, 1, 0, 2'b01, 2'b10, {32'hAA, 32'hBB}, {32'hCC, 32'hDD}, {32'h11, 32'h22}, 2'b10);
        drive(0, 1, 0, 2'b10, 2'b11, {32'h1, 32'h2}, {32'h3, 32'h4}, {32'h5, 32'h6}, 2'b11);
        drive(0, 1, 0, 2'b00, 2'b00, '1, '1, '1, 2'b11);
        // Kill lane 1: its overflow must not propagate.
        drive(0, 0, 0, 2'b10, 2'b11, {32'h44, 32'h33}, {32'h66, 32'h55},
              {32'h0000_0777, 32'h0000_0888}, 2'b11);
        // Lane 0 is invalid and lane 1 loads. The two lanes are independent.
        drive(0, 0, 0, 2'b00, 2'b10, {32'hDEAD, 32'hBEEF}, {32'h1234, 32'h5678},
              {32'hCAFE_0001, 32'hCAFE_0002}, 2'b11);
        // Flush and stall together: flush wins and the stall count is unchanged.
        drive(0, 1, 1, 2'b00, 2'b11, {32'h7, 32'h8}, {32'h9, 32'hA}, {32'hB, 32'hC}, 2'b11);
        // Reload both lanes, stall, then assert reset while the stall is still held.
        drive(0, 0, 0, 2'b00, 2'b11, {32'h10, 32'h20}, {32'h30, 32'h40}, {32'h50, 32'h60}, 2'b10);
        drive(0, 1, 0, 2'b00, 2'b11, '0, '0, '0, 2'b00);
        drive(1, 1, 0, 2'b00, 2'b11, '1, '1, '1, 2'b11);
        // Load, then flush alone.
        drive(0, 0, 0, 2'b01, 2'b11, {32'hF0, 32'hF1}, {32'hF2, 32'hF3}, {32'hF4, 32'hF5}, 2'b11);
        drive(0, 0, 1, 2'b00, 2'b11, '1, '1, '1, 2'b11);
        // Run 20 stall cycles so the stall counter reaches saturation, then reset.
        drive(0, 0, 0, 2'b00, 2'b11, {32'h1, 32'h2}, {32'h3, 32'h4}, {32'h5, 32'h6}, 2'b01);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 2'b00, 2'b11, 64'(i), 64'(i), 64'(i), 2'b11);
        end
        drive(1, 0, 0, 2'b00, 2'b00, '0, '0, '0, 2'b00);
        // Drain, with a bounded wait.
        drive(0, 0, 0, 2'b00, 2'b00, '0, '0, '0, 2'b00);
        repeat (4) @(posedge clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
